issue_ctrl: RTL and testbench
=============================

# issue_ctrl

In-order issue controller between the instruction decoder and the execution units (ALU, LSU, system unit). It holds a 32-entry register scoreboard and stalls the decoder on RAW and WAW hazards. It limits outstanding LSU operations and serialises system instructions by draining all in-flight work before issuing them. The decoder supplies register fields and a unit select; this block decides, cycle by cycle, whether and where the instruction issues.

## Interface
Parameters:
- NUM_REGS, 32, scoreboard entries; index 0 (x0) is never marked busy.
- LSU_MAX_OUTSTANDING, 2, maximum issued-but-not-done LSU ops (1..7).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- dec_valid_i  in  1  decoder presents an instruction.
- dec_ready_o  out  1  instruction consumed this cycle.
- rs1_i, rs2_i, rd_i  in  5 each  register indices.
- use_rs1_i, use_rs2_i, wr_rd_i  in  1 each  operand-read and destination-write flags.
- unit_i  in  2  target: 0 = ALU, 1 = LSU, 2 = SYS, 3 = reserved.
- alu_ready_i / alu_issue_o  in / out  1  ALU handshake.
- lsu_ready_i / lsu_issue_o  in / out  1  LSU handshake.
- sys_issue_o  out  1  one-cycle system-instruction issue pulse.
- alu_wb_valid_i, alu_wb_rd_i  in  1, 5  ALU writeback, clears busy[rd].
- lsu_wb_valid_i, lsu_wb_rd_i  in  1, 5  load writeback, clears busy[rd].
- lsu_done_i  in  1  one LSU op (load or store) completed.
- flush_i  in  1  abandon the current decoder instruction.
- busy_o  out  NUM_REGS  registered scoreboard.
- stall_o  out  1  dec_valid_i high and dec_ready_o low.
- illegal_o  out  1  reserved unit code consumed and dropped.

## Operation
- Hazard condition: (use_rs1 & busy[rs1]) | (use_rs2 & busy[rs2]) | (wr_rd & busy[rd]). busy[0] is always 0.
- The scoreboard is read from registered state only. There is no writeback bypass: a writeback in cycle N allows a dependent issue in cycle N+1.
- Fire conditions, evaluated in RUN only, with dec_valid_i=1 and no flush:
  - ALU fires when unit=0, no hazard and alu_ready_i=1.
  - LSU fires when unit=1, no hazard, lsu_ready_i=1 and lsu_cnt < LSU_MAX_OUTSTANDING.
  - dec_ready_o equals the fire of the selected unit.
- On fire with wr_rd_i=1 and rd≠0, busy[rd] is set at the next edge.
- Writebacks clear busy[rd]. Both writeback ports may clear in the same cycle. If a set and a clear hit the same index in one cycle, the set wins.
- lsu_cnt, 3 bits:
  - +1 on lsu_issue_o, −1 on lsu_done_i; unchanged when both occur.
  - lsu_done_i with lsu_cnt=0 is ignored.
- FSM states RUN, DRAIN, SYS:
  - RUN → DRAIN when dec_valid_i=1 and unit=2. No issue happens in that cycle.
  - DRAIN holds dec_ready_o=0 until busy==0 and lsu_cnt==0, then → SYS.
  - SYS asserts sys_issue_o=1 and dec_ready_o=1 for exactly one cycle, then → RUN.
- unit=3 in RUN: dec_ready_o=1 and illegal_o=1 for one cycle. Nothing issues and the scoreboard is unchanged.
- flush_i: all issue outputs and dec_ready_o are 0 that cycle, and the FSM goes to RUN at the next edge. The scoreboard and lsu_cnt are kept so in-flight writebacks and dones retire normally.

## Timing
- Reset values: FSM=RUN, busy_o=0, lsu_cnt=0.
  - While rst=1, alu_issue_o, lsu_issue_o, sys_issue_o, dec_ready_o, stall_o and illegal_o are forced to 0.
  - Reset mid-DRAIN returns to RUN with the scoreboard cleared.
- Issue latency: 0 cycles. The issue outputs are combinational from the registered state and current inputs; the scoreboard update is visible 1 cycle later.
- Minimum SYS latency from presentation with an empty machine: DRAIN for 1 cycle, then the SYS issue in the next cycle, for 2 cycles total.
- Back-to-back independent ALU issues are sustained at 1 per cycle.

## Test plan
- ALU issue with rd=x5, then a dependent instruction reading x5 → second held with stall_o=1 until alu_wb_valid_i with rd=5; issues exactly 1 cycle after the writeback.
- Issue three independent loads with LSU_MAX_OUTSTANDING=2 and no lsu_done_i → the third stalls; lsu_done_i pulse → the third issues on the following cycle.
- SYS instruction with busy[7]=1 and lsu_cnt=1 → dec_ready_o=0 until both clear, then a single sys_issue_o pulse and return to RUN.
- Same-cycle ALU writeback to x3 and LSU writeback to x9 → busy_o[3] and busy_o[9] both 0 next cycle; instruction with rd=x0 → busy_o stays 0.
- flush_i asserted during DRAIN → no sys_issue_o, FSM in RUN next cycle, pending busy bits retained and cleared by later writebacks.
- unit_i=3 → illegal_o pulse, dec_ready_o=1, busy_o and lsu_cnt unchanged; rst mid-stream → all outputs 0 and busy_o=0 the next cycle.

Source files
------------

// File: rtl/issue_ctrl_if.sv
// Decoder-to-issue-controller bundle: instruction fields and the
// valid/ready handshake. The master is the decoder, the slave is issue_ctrl.
interface issue_ctrl_if;
    logic       dec_valid_i;
    logic       dec_ready_o;
    logic [4:0] rs1_i;
    logic [4:0] rs2_i;
    logic [4:0] rd_i;
    logic       use_rs1_i;
    logic       use_rs2_i;
    logic       wr_rd_i;
    logic [1:0] unit_i;

    modport master (
        output dec_valid_i, rs1_i, rs2_i, rd_i,
        output use_rs1_i, use_rs2_i, wr_rd_i, unit_i,
        input  dec_ready_o
    );

    modport slave (
        input  dec_valid_i, rs1_i, rs2_i, rd_i,
        input  use_rs1_i, use_rs2_i, wr_rd_i, unit_i,
        output dec_ready_o
    );
endinterface

// File: rtl/issue_ctrl.sv
// issue_ctrl: in-order issue controller. Keeps a register scoreboard to
// block RAW/WAW hazards, bounds outstanding LSU operations and serialises
// system instructions by draining all in-flight work before issuing them.
module issue_ctrl #(
    parameter int NUM_REGS            = 32,
    parameter int LSU_MAX_OUTSTANDING = 2
) (
    input  logic                clk,
    input  logic                rst,
    issue_ctrl_if.slave         dec,
    input  logic                alu_ready_i,
    output logic                alu_issue_o,
    input  logic                lsu_ready_i,
    output logic                lsu_issue_o,
    output logic                sys_issue_o,
    input  logic                alu_wb_valid_i,
    input  logic [4:0]          alu_wb_rd_i,
    input  logic                lsu_wb_valid_i,
    input  logic [4:0]          lsu_wb_rd_i,
    input  logic                lsu_done_i,
    input  logic                flush_i,
    output logic [NUM_REGS-1:0] busy_o,
    output logic                stall_o,
    output logic                illegal_o
);

    localparam logic [1:0] UNIT_ALU  = 2'd0;
    localparam logic [1:0] UNIT_LSU  = 2'd1;
    localparam logic [1:0] UNIT_SYS  = 2'd2;
    localparam logic [1:0] UNIT_RSVD = 2'd3;
    localparam logic [2:0] LSU_MAX   = 3'(LSU_MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_SYS
    } state_t;

    state_t              state_q;
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [2:0]          lsuCnt_q;
    logic [2:0]          lsuCnt_d;

    logic hazard;
    logic inRun;
    logic canAct;
    logic lsuDoneCounts;
    logic machineEmpty;

    assign busy_o       = busy_q;
    assign machineEmpty = (busy_q == '0) && (lsuCnt_q == 3'd0);

    // Decide this cycle's issue from registered scoreboard/count and live inputs
    always_comb begin
        hazard = (dec.use_rs1_i & busy_q[dec.rs1_i])
               | (dec.use_rs2_i & busy_q[dec.rs2_i])
               | (dec.wr_rd_i   & busy_q[dec.rd_i]);
        inRun  = (state_q == ST_RUN);
        canAct = !rst && !flush_i && dec.dec_valid_i && inRun;

        alu_issue_o = canAct && (dec.unit_i == UNIT_ALU) && !hazard && alu_ready_i;
        lsu_issue_o = canAct && (dec.unit_i == UNIT_LSU) && !hazard && lsu_ready_i
                      && (lsuCnt_q < LSU_MAX);
        illegal_o   = canAct && (dec.unit_i == UNIT_RSVD);
        sys_issue_o = !rst && !flush_i && (state_q == ST_SYS);

        dec.dec_ready_o = alu_issue_o | lsu_issue_o | illegal_o | sys_issue_o;
        stall_o         = !rst && dec.dec_valid_i && !dec.dec_ready_o;
    end

    // Scoreboard next state: writebacks clear, an issuing writer sets and wins
    always_comb begin
        busy_d = busy_q;
        if (alu_wb_valid_i) begin
            busy_d[alu_wb_rd_i] = 1'b0;
        end
        if (lsu_wb_valid_i) begin
            busy_d[lsu_wb_rd_i] = 1'b0;
        end
        if ((alu_issue_o || lsu_issue_o) && dec.wr_rd_i && (dec.rd_i != 5'd0)) begin
            busy_d[dec.rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Outstanding LSU count; a completion with nothing outstanding is ignored
    always_comb begin
        lsuDoneCounts = lsu_done_i && (lsuCnt_q != 3'd0);
        lsuCnt_d      = lsuCnt_q;
        if (lsu_issue_o && !lsuDoneCounts) begin
            lsuCnt_d = lsuCnt_q + 3'd1;
        end else if (!lsu_issue_o && lsuDoneCounts) begin
            lsuCnt_d = lsuCnt_q - 3'd1;
        end
    end

    // Scoreboard and LSU counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= '0;
            lsuCnt_q <= 3'd0;
        end else begin
            busy_q   <= busy_d;
            lsuCnt_q <= lsuCnt_d;
        end
    end

    // System-instruction sequencer: wait for an empty machine, then issue once
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else if (flush_i) begin
            state_q <= ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (dec.dec_valid_i && (dec.unit_i == UNIT_SYS)) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (machineEmpty) begin
                        state_q <= ST_SYS;
                    end
                end
                ST_SYS: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the issue rules.
module tb_issue_ctrl;

    localparam int NREGS = 32;
    localparam int LMAX  = 2;

    logic             clk;
    logic             rst;
    logic             alu_ready_i;
    logic             alu_issue_o;
    logic             lsu_ready_i;
    logic             lsu_issue_o;
    logic             sys_issue_o;
    logic             alu_wb_valid_i;
    logic [4:0]       alu_wb_rd_i;
    logic             lsu_wb_valid_i;
    logic [4:0]       lsu_wb_rd_i;
    logic             lsu_done_i;
    logic             flush_i;
    logic [NREGS-1:0] busy_o;
    logic             stall_o;
    logic             illegal_o;

    issue_ctrl_if decIf();

    issue_ctrl #(
        .NUM_REGS           (NREGS),
        .LSU_MAX_OUTSTANDING(LMAX)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .dec           (decIf),
        .alu_ready_i   (alu_ready_i),
        .alu_issue_o   (alu_issue_o),
        .lsu_ready_i   (lsu_ready_i),
        .lsu_issue_o   (lsu_issue_o),
        .sys_issue_o   (sys_issue_o),
        .alu_wb_valid_i(alu_wb_valid_i),
        .alu_wb_rd_i   (alu_wb_rd_i),
        .lsu_wb_valid_i(lsu_wb_valid_i),
        .lsu_wb_rd_i   (lsu_wb_rd_i),
        .lsu_done_i    (lsu_done_i),
        .flush_i       (flush_i),
        .busy_o        (busy_o),
        .stall_o       (stall_o),
        .illegal_o     (illegal_o)
    );

    int total;
    int bad;

    // Behavioural model state: which registers await a result, how many LSU
    // ops are in flight, and whether a system instruction is waiting/issuing.
    bit   mBusy [NREGS];
    int   mLsu;
    bit   mSysWaiting;
    bit   mSysNow;
    logic eAlu, eLsu, eSys, eReady, eStall, eIll;
    logic [5:0] expOut;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [NREGS-1:0] modelBusyVec();
        logic [NREGS-1:0] v;
        for (int i = 0; i < NREGS; i++) v[i] = mBusy[i];
        return v;
    endfunction

    function automatic logic [5:0] outsNow();
        return {alu_issue_o, lsu_issue_o, sys_issue_o, decIf.dec_ready_o, stall_o, illegal_o};
    endfunction

    function automatic bit modelIdle();
        bit any;
        any = 1'b0;
        for (int i = 0; i < NREGS; i++) any |= mBusy[i];
        return !any && (mLsu == 0);
    endfunction

    task automatic computeExpect();
        bit hz;
        bit run;
        bit go;
        hz  = (decIf.use_rs1_i && mBusy[decIf.rs1_i]) ||
              (decIf.use_rs2_i && mBusy[decIf.rs2_i]) ||
              (decIf.wr_rd_i   && mBusy[decIf.rd_i]);
        run = !mSysWaiting && !mSysNow;
        go  = !rst && !flush_i && decIf.dec_valid_i && run;
        eAlu   = go && decIf.unit_i == 2'd0 && !hz && alu_ready_i;
        eLsu   = go && decIf.unit_i == 2'd1 && !hz && lsu_ready_i && (mLsu < LMAX);
        eIll   = go && decIf.unit_i == 2'd3;
        eSys   = !rst && !flush_i && mSysNow;
        eReady = eAlu || eLsu || eIll || eSys;
        eStall = !rst && decIf.dec_valid_i && !eReady;
        expOut = {eAlu, eLsu, eSys, eReady, eStall, eIll};
    endtask

    task automatic advanceModel();
        bit empty;
        bit doneCounts;
        if (rst) begin
            for (int i = 0; i < NREGS; i++) mBusy[i] = 1'b0;
            mLsu = 0;
            mSysWaiting = 1'b0;
            mSysNow = 1'b0;
            return;
        end
        empty = modelIdle();
        if (alu_wb_valid_i) mBusy[alu_wb_rd_i] = 1'b0;
        if (lsu_wb_valid_i) mBusy[lsu_wb_rd_i] = 1'b0;
        if ((eAlu || eLsu) && decIf.wr_rd_i && decIf.rd_i != 5'd0) mBusy[decIf.rd_i] = 1'b1;
        doneCounts = lsu_done_i && (mLsu > 0);
        if (eLsu && !doneCounts) mLsu = mLsu + 1;
        else if (!eLsu && doneCounts) mLsu = mLsu - 1;
        if (flush_i) begin
            mSysWaiting = 1'b0;
            mSysNow = 1'b0;
        end else if (mSysNow) begin
            mSysNow = 1'b0;
        end else if (mSysWaiting) begin
            if (empty) begin
                mSysWaiting = 1'b0;
                mSysNow = 1'b1;
            end
        end else if (decIf.dec_valid_i && decIf.unit_i == 2'd2) begin
            mSysWaiting = 1'b1;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        computeExpect();
    endtask

    task automatic advance();
        @(posedge clk);
        advanceModel();
        #1;
    endtask

    task automatic idle();
        decIf.dec_valid_i = 1'b0;
        decIf.unit_i      = 2'd0;
        decIf.rs1_i       = 5'd0;
        decIf.rs2_i       = 5'd0;
        decIf.rd_i        = 5'd0;
        decIf.use_rs1_i   = 1'b0;
        decIf.use_rs2_i   = 1'b0;
        decIf.wr_rd_i     = 1'b0;
        alu_ready_i       = 1'b1;
        lsu_ready_i       = 1'b1;
        alu_wb_valid_i    = 1'b0;
        alu_wb_rd_i       = 5'd0;
        lsu_wb_valid_i    = 1'b0;
        lsu_wb_rd_i       = 5'd0;
        lsu_done_i        = 1'b0;
        flush_i           = 1'b0;
    endtask

    task automatic present(input logic [1:0] u, input logic [4:0] r1, input logic u1,
                           input logic [4:0] r2, input logic u2,
                           input logic [4:0] d, input logic w);
        decIf.dec_valid_i = 1'b1;
        decIf.unit_i      = u;
        decIf.rs1_i       = r1;
        decIf.use_rs1_i   = u1;
        decIf.rs2_i       = r2;
        decIf.use_rs2_i   = u2;
        decIf.rd_i        = d;
        decIf.wr_rd_i     = w;
    endtask

    // Writes back every pending register and completes outstanding LSU ops
    task automatic retireAll();
        for (int n = 0; n < 40; n++) begin
            if (modelIdle() && !mSysWaiting && !mSysNow) break;
            idle();
            for (int j = 1; j < NREGS; j++) begin
                if (mBusy[j]) begin
                    alu_wb_valid_i = 1'b1;
                    alu_wb_rd_i    = 5'(j);
                    break;
                end
            end
            lsu_done_i = (mLsu > 0);
            settle();
            advance();
        end
        idle();
    endtask

    task automatic test_reset();
        present(2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
        settle();
        total++;
        if (outsNow() !== 6'b0) begin
            bad++;
            $display("[TB] FAIL reset_outs got=%b want=%b", outsNow(), 6'b0);
        end
        total++;
        if (busy_o !== '0) begin
            bad++;
            $display("[TB] FAIL reset_busy got=%h want=0", busy_o);
        end
        advance();
        rst = 1'b0;
        idle();
    endtask

    task automatic test_raw_hazard();
        present(2'd0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1);
        settle();
        total++;
        if (outsNow() !== expOut || alu_issue_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL raw_first got=%b want=%b", outsNow(), expOut);
        end
        advance();
        total++;
        if (busy_o[5] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL raw_busy5 got=%b want=1", busy_o[5]);
        end
        present(2'd0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1);
        for (int c = 0; c < 5; c++) begin
            alu_wb_valid_i = (c == 3);
            alu_wb_rd_i    = 5'd5;
            settle();
            total++;
            if (c < 4 && (stall_o !== 1'b1 || alu_issue_o !== 1'b0)) begin
                bad++;
                $display("[TB] FAIL raw_stall c=%0d got=%b%b want=10", c, stall_o, alu_issue_o);
            end else if (c == 4 && (alu_issue_o !== 1'b1 || stall_o !== 1'b0)) begin
                bad++;
                $display("[TB] FAIL raw_issue_after_wb got=%b%b want=10", alu_issue_o, stall_o);
            end else if (outsNow() !== expOut) begin
                bad++;
                $display("[TB] FAIL raw_model c=%0d got=%b want=%b", c, outsNow(), expOut);
            end
            advance();
        end
        idle();
        retireAll();
    endtask

    task automatic test_lsu_limit();
        for (int c = 0; c < 6; c++) begin
            present(2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(10 + (c < 2 ? c : 2)), 1'b1);
            lsu_done_i = (c == 4);
            settle();
            total++;
            if ((c < 2 || c == 5) && lsu_issue_o !== 1'b1) begin
                bad++;
                $display("[TB] FAIL lsu_issue c=%0d got=%b want=1", c, lsu_issue_o);
            end else if (c >= 2 && c < 5 && (lsu_issue_o !== 1'b0 || stall_o !== 1'b1)) begin
                bad++;
                $display("[TB] FAIL lsu_third_stall c=%0d got=%b%b want=01", c, lsu_issue_o, stall_o);
            end else if (outsNow() !== expOut) begin
                bad++;
                $display("[TB] FAIL lsu_model c=%0d got=%b want=%b", c, outsNow(), expOut);
            end
            advance();
        end
        idle();
        retireAll();
    endtask

    task automatic test_sys_drain();
        int sysCount;
        sysCount = 0;
        present(2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        settle();
        advance();
        present(2'd1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        settle();
        advance();
        for (int c = 0; c < 10; c++) begin
            if (c <= 8) present(2'd2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
            else present(2'd0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0);
            alu_wb_valid_i = (c == 3);
            alu_wb_rd_i    = 5'd7;
            lsu_done_i     = (c == 6);
            settle();
            if (sys_issue_o === 1'b1) sysCount++;
            total++;
            if (c < 8 && decIf.dec_ready_o !== 1'b0) begin
                bad++;
                $display("[TB] FAIL sys_hold c=%0d got=%b want=0", c, decIf.dec_ready_o);
            end else if (c == 8 && (sys_issue_o !== 1'b1 || decIf.dec_ready_o !== 1'b1)) begin
                bad++;
                $display("[TB] FAIL sys_pulse got=%b%b want=11", sys_issue_o, decIf.dec_ready_o);
            end else if (c == 9 && alu_issue_o !== 1'b1) begin
                bad++;
                $display("[TB] FAIL sys_back_to_run got=%b want=1", alu_issue_o);
            end else if (outsNow() !== expOut) begin
                bad++;
                $display("[TB] FAIL sys_model c=%0d got=%b want=%b", c, outsNow(), expOut);
            end
            advance();
        end
        total++;
        if (sysCount != 1) begin
            bad++;
            $display("[TB] FAIL sys_count got=%0d want=1", sysCount);
        end
        idle();
        retireAll();
    endtask

    task automatic test_dual_wb();
        present(2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        settle();
        advance();
        present(2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
        settle();
        advance();
        idle();
        alu_wb_valid_i = 1'b1;
        alu_wb_rd_i    = 5'd3;
        lsu_wb_valid_i = 1'b1;
        lsu_wb_rd_i    = 5'd9;
        lsu_done_i     = 1'b1;
        settle();
        total++;
        if (busy_o[3] !== 1'b1 || busy_o[9] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL dual_pre got=%b%b want=11", busy_o[3], busy_o[9]);
        end
        advance();
        idle();
        present(2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        settle();
        total++;
        if (busy_o[3] !== 1'b0 || busy_o[9] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL dual_clear got=%b%b want=00", busy_o[3], busy_o[9]);
        end
        total++;
        if (alu_issue_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL x0_issue got=%b want=1", alu_issue_o);
        end
        advance();
        idle();
        settle();
        total++;
        if (busy_o !== '0) begin
            bad++;
            $display("[TB] FAIL x0_busy got=%h want=0", busy_o);
        end
        advance();
    endtask

    task automatic test_flush_drain();
        present(2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
        settle();
        advance();
        present(2'd2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        settle();
        advance();
        settle();
        total++;
        if (stall_o !== 1'b1 || outsNow() !== expOut) begin
            bad++;
            $display("[TB] FAIL flush_draining got=%b want=%b", outsNow(), expOut);
        end
        advance();
        flush_i = 1'b1;
        settle();
        total++;
        if (sys_issue_o !== 1'b0 || decIf.dec_ready_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL flush_outs got=%b%b want=00", sys_issue_o, decIf.dec_ready_o);
        end
        advance();
        idle();
        present(2'd0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        settle();
        total++;
        if (alu_issue_o !== 1'b1 || sys_issue_o !== 1'b0 || busy_o[4] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL flush_run got=%b%b%b want=101", alu_issue_o, sys_issue_o, busy_o[4]);
        end
        advance();
        idle();
        alu_wb_valid_i = 1'b1;
        alu_wb_rd_i    = 5'd4;
        settle();
        advance();
        idle();
        settle();
        total++;
        if (busy_o[4] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL flush_late_wb got=%b want=0", busy_o[4]);
        end
        advance();
    endtask

    task automatic test_illegal();
        present(2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        settle();
        advance();
        present(2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1);
        settle();
        advance();
        present(2'd3, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1);
        settle();
        total++;
        if (outsNow() !== 6'b000101) begin
            bad++;
            $display("[TB] FAIL illegal_outs got=%b want=%b", outsNow(), 6'b000101);
        end
        advance();
        present(2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        settle();
        total++;
        if (busy_o[12] !== 1'b0 || busy_o[8] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL illegal_busy got=%b%b want=01", busy_o[12], busy_o[8]);
        end
        total++;
        if (lsu_issue_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL illegal_cnt_a got=%b want=1", lsu_issue_o);
        end
        advance();
        settle();
        total++;
        if (lsu_issue_o !== 1'b0 || stall_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL illegal_cnt_b got=%b%b want=01", lsu_issue_o, stall_o);
        end
        advance();
        idle();
        retireAll();
    endtask

    task automatic test_reset_mid();
        present(2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1);
        settle();
        advance();
        present(2'd2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        settle();
        advance();
        rst = 1'b1;
        settle();
        total++;
        if (outsNow() !== 6'b0) begin
            bad++;
            $display("[TB] FAIL rstmid_outs got=%b want=%b", outsNow(), 6'b0);
        end
        advance();
        rst = 1'b0;
        idle();
        present(2'd0, 5'd13, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        settle();
        total++;
        if (busy_o !== '0 || alu_issue_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rstmid_after got=%h/%b want=0/1", busy_o, alu_issue_o);
        end
        advance();
        idle();
    endtask

    task automatic test_random();
        int u;
        for (int c = 0; c < 600; c++) begin
            rst               = ($urandom_range(0, 99) == 0);
            flush_i           = ($urandom_range(0, 19) == 0);
            decIf.dec_valid_i = ($urandom_range(0, 3) != 0);
            u = $urandom_range(0, 9);
            decIf.unit_i      = (u < 5) ? 2'd0 : (u < 8) ? 2'd1 : (u == 8) ? 2'd2 : 2'd3;
            decIf.rs1_i       = 5'($urandom_range(0, 7));
            decIf.rs2_i       = 5'($urandom_range(0, 7));
            decIf.rd_i        = 5'($urandom_range(0, 7));
            decIf.use_rs1_i   = 1'($urandom_range(0, 1));
            decIf.use_rs2_i   = 1'($urandom_range(0, 1));
            decIf.wr_rd_i     = 1'($urandom_range(0, 1));
            alu_ready_i       = ($urandom_range(0, 3) != 0);
            lsu_ready_i       = ($urandom_range(0, 3) != 0);
            alu_wb_valid_i    = ($urandom_range(0, 2) == 0);
            alu_wb_rd_i       = 5'($urandom_range(0, 7));
            lsu_wb_valid_i    = ($urandom_range(0, 3) == 0);
            lsu_wb_rd_i       = 5'($urandom_range(0, 7));
            lsu_done_i        = (mLsu > 0) && ($urandom_range(0, 2) == 0);
            settle();
            total++;
            if (outsNow() !== expOut) begin
                bad++;
                $display("[TB] FAIL rand_outs c=%0d got=%b want=%b", c, outsNow(), expOut);
            end
            total++;
            if (busy_o !== modelBusyVec()) begin
                bad++;
                $display("[TB] FAIL rand_busy c=%0d got=%h want=%h", c, busy_o, modelBusyVec());
            end
            advance();
        end
        rst = 1'b0;
        idle();
        retireAll();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < NREGS; i++) mBusy[i] = 1'b0;
        mLsu        = 0;
        mSysWaiting = 1'b0;
        mSysNow     = 1'b0;
        rst = 1'b1;
        idle();
        settle();
        advance();
        settle();
        advance();
        test_reset();
        test_raw_hazard();
        test_lsu_limit();
        test_sys_drain();
        test_dual_wb();
        test_flush_drain();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
